spi_cfg_writer: RTL and testbench
=================================

# spi_cfg_writer

On-chip SPI write controller that configures the team's SPI register peripheral: output enables at 0x00/0x01, PWM enables at 0x02/0x03, duty cycle at 0x04. It arbitrates round-robin between two internal requesters, each presenting one 7-bit-address/8-bit-data register write. It serializes each granted write as a 16-bit mode-0 SPI frame on `sclk`/`copi`/`ncs`. It sits between firmware/sequencer logic and the peripheral's SPI pins.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period. Legal range is ≥3 so the peripheral's 2-FF sync plus edge detect sees every edge.
- `GAP_CYCLES`, default 4: `clk` cycles `ncs` stays high between frames. Legal range is ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester write request.
- `req_addr0`, `req_addr1`  in  7 each  target register address.
- `req_data0`, `req_data1`  in  8 each  write data.
- `req_ready`  out  2  per-requester accept; a transfer occurs on `req_valid[i] & req_ready[i]`.
- `sclk`  out  1  SPI clock; idles low.
- `copi`  out  1  SPI data, MSB first.
- `ncs`  out  1  chip select, active low.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a frame completes.
- `done_id`  out  1  requester index of the completed frame; valid with `done`.
- `err`  out  1  one-cycle pulse on a dropped request (see Configuration).

## Operation
- Reset values: `req_ready`=0, `sclk`=0, `copi`=0, `ncs`=1, `busy`=0, `done`=0, `done_id`=0, `err`=0. The round-robin pointer is reset so requester 0 is preferred.
- FSM states: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - `req_ready` is combinational and one-hot: at most one bit is high, and only in IDLE.
  - The granted requester is the one with `req_valid` set. If both are valid, grant the one not granted last.
  - On handshake, capture frame = {1'b1, addr, data}, record the id, update the pointer, and go to SETUP.
- SETUP: `ncs`=0, `sclk`=0, `copi`=frame[15]. Hold for `CLK_DIV` cycles, then go to SHIFT.
- SHIFT: 16 SCLK periods.
  - `sclk` rises after each `CLK_DIV` low cycles and falls after `CLK_DIV` high cycles.
  - On each falling edge `copi` advances to the next bit.
  - After the 16th falling edge `copi` holds frame[0], and the FSM goes to HOLD.
  - The bit counter is 5 bits wide and counts 0..15; it never wraps within a frame.
- HOLD: `sclk`=0 for `CLK_DIV` cycles. Then drive `ncs`=1, pulse `done` with `done_id`, and go to GAP.
- GAP: `ncs`=1 for `GAP_CYCLES` cycles, then go to IDLE. `req_ready` stays 0 throughout GAP.
- Requester rules:
  - Requests arriving while busy wait; `req_valid` must stay asserted until accepted.
  - Dropping `req_valid` before accept withdraws the request with no side effects.
- Simultaneous events: if both requesters become valid in the same cycle, only one is granted. The other is granted in the next IDLE, giving strict alternation under continuous load.
- Reset mid-frame: on the next edge `ncs`=1 and `sclk`=0. The frame is abandoned, with no `done` and no `err`. Because `ncs` rises, the peripheral also aborts.

## Timing
- Handshake in cycle T:
  - `ncs` falls in cycle T+1.
  - The first `sclk` rise is at T+1+`CLK_DIV`.
  - The 16th rise is at T+1+31·`CLK_DIV`.
  - `ncs` rises, and `done` pulses, in cycle T+1+33·`CLK_DIV`.
- `ncs` low time is exactly 33·`CLK_DIV` cycles, i.e. 132 cycles at the default.
- Next possible handshake: cycle T+1+33·`CLK_DIV`+`GAP_CYCLES`, i.e. T+137 at the defaults.
- `copi` is stable for ≥`CLK_DIV` cycles on both sides of every `sclk` rise.
- All outputs except `req_ready` are registered.

## Configuration
- Macro: `SPI_CFG_ADDR_CHECK_EN`.
- Defined:
  - A handshake with addr > 0x04 is accepted but not transmitted.
  - `err` pulses in cycle T+1 and the FSM returns to IDLE. There is no GAP, `ncs`, or `done` activity.
  - The round-robin pointer still advances.
- Undefined: every address is transmitted, and `err` is tied to 0.

## Structure
- Shared package `spi_cfg_pkg`:
  - register address constants: `ADDR_EN_OUT_LO`=0x00, `ADDR_EN_OUT_HI`=0x01, `ADDR_EN_PWM_LO`=0x02, `ADDR_EN_PWM_HI`=0x03, `ADDR_PWM_DUTY`=0x04, `ADDR_MAX`=0x04;
  - `FRAME_W`=16;
  - the FSM state enum.
- One sub-module, `spi_clk_div`: a half-period tick counter that is cleared on state entry and emits a one-cycle `tick` every `CLK_DIV` cycles. The FSM consumes `tick`.

## Test plan
- Reset, then req0 writes addr 0x04, data 0xA5:
  - `copi` sampled at each `sclk` rise reads 0x84A5;
  - `ncs` is low for 132 cycles;
  - `done`=1 with `done_id`=0.
- Loopback into the SPI peripheral: req0 writes (0x00, 0xF0), then req1 writes (0x03, 0x0F). Peripheral `en_reg_out_7_0`=0xF0 and `en_reg_pwm_15_8`=0x0F.
- Both `req_valid` held continuously with distinct data: grants alternate 0,1,0,1, and each handshake is 137 cycles after the previous one.
- Assert `rst` at the 8th `sclk` rise: the next cycle has `ncs`=1 and `sclk`=0; there is no `done`; the peripheral registers are unchanged.
- With `SPI_CFG_ADDR_CHECK_EN`, req1 writes addr 0x05: `err` pulses in T+1, `ncs` stays 1, and `req_ready` returns in T+1. Without the macro, the frame 0x85xx is transmitted.
- `CLK_DIV`=3, `GAP_CYCLES`=2, req0 writes (0x01, 0x3C): `ncs` low for 99 cycles, and the peripheral `en_reg_out_15_8`=0x3C.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_cfg_pkg: register map, frame width and FSM states for the writer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spi_cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
  localparam logic [6:0] ADDR_MAX       = 7'h04;

  localparam int FRAME_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_cfg_writer_clk_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_clk_div: half-period tick counter, restarted on every state entry |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_clk_div
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d = (clr || tick) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/spi_cfg_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_cfg_writer: round-robin SPI mode-0 register writer (16-bit frame) |
// | Option: SPI_CFG_ADDR_CHECK_EN drops writes above ADDR_MAX with err.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_cfg_writer
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [6:0] req_addr0,
  input  logic [6:0] req_addr1,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic       err
);

  localparam int         GAP_W    = $clog2(GAP_CYCLES);
  localparam logic [4:0] LAST_BIT = 5'd15;

  state_e               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic                 id_q, id_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 copi_q, copi_d;
  logic                 ncs_q, ncs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 done_id_q, done_id_d;
  logic                 err_q, err_d;

  logic                 tick;
  logic                 state_change;
  logic                 handshake;
  logic                 addr_bad;
  logic                 gnt_id;
  logic [1:0]           gnt_oh;
  logic [6:0]           gnt_addr;
  logic [7:0]           gnt_data;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_change),
    .tick (tick)
  );

  // ptr_q names the requester preferred when both are valid.
  always_comb begin
    gnt_id = (&req_valid) ? ptr_q : req_valid[1];
    gnt_oh = 2'b00;
    if (|req_valid) gnt_oh = gnt_id ? 2'b10 : 2'b01;
    gnt_addr = gnt_id ? req_addr1 : req_addr0;
    gnt_data = gnt_id ? req_data1 : req_data0;
  end

  assign handshake    = (state_q == ST_IDLE) && (|req_valid);
  assign state_change = (state_d != state_q);

`ifdef SPI_CFG_ADDR_CHECK_EN
  assign addr_bad = (gnt_addr > ADDR_MAX);
`else
  assign addr_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      id_q      <= 1'b0;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      ncs_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      ncs_q     <= ncs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          ptr_d     = ~gnt_id;
          id_d      = gnt_id;
          frame_d   = {1'b1, gnt_addr, gnt_data};
          bit_cnt_d = '0;
          if (!addr_bad) state_d = ST_SETUP;
        end
      end
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: begin
        // Falling edges only; the 16th fall leaves the last bit on copi.
        if (tick && sclk_q) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            frame_d   = {frame_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                                     gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    ncs_d     = ncs_q;
    busy_d    = (state_d != ST_IDLE);
    done_d    = 1'b0;
    done_id_d = done_id_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt_oh;
        if (handshake) begin
          if (addr_bad) begin
            err_d = 1'b1;
          end else begin
            ncs_d  = 1'b0;
            sclk_d = 1'b0;
            copi_d = 1'b1;
          end
        end
      end
      ST_SETUP: if (tick) sclk_d = 1'b1;
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q && (bit_cnt_q != LAST_BIT)) copi_d = frame_q[FRAME_W-2];
        end
      end
      ST_HOLD: begin
        if (tick) begin
          ncs_d     = 1'b1;
          done_d    = 1'b1;
          done_id_d = id_q;
        end
      end
      default: ;
    endcase
  end

  assign sclk    = sclk_q;
  assign copi    = copi_q;
  assign ncs     = ncs_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_cfg_writer: directed/random bench with SPI peripheral model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spi_cfg_writer;
  import spi_cfg_pkg::*;

  localparam int CD     = 4;
  localparam int GAP    = 4;
  localparam int CD3    = 3;
  localparam int GAP3   = 2;
  localparam int PERIOD = 1 + 33 * CD + GAP;
`ifdef SPI_CFG_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [6:0] req_addr0 = '0, req_addr1 = '0;
  logic [7:0] req_data0 = '0, req_data1 = '0;
  logic [1:0] req_ready;
  logic       sclk, copi, ncs, busy, done, done_id, err;

  logic [1:0] req_valid3 = 2'b00;
  logic [6:0] req_addr3 = '0;
  logic [7:0] req_data3 = '0;
  logic [1:0] req_ready3;
  logic       sclk3, copi3, ncs3, busy3, done3, done_id3, err3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_cfg_writer #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .sclk(sclk), .copi(copi), .ncs(ncs),
    .busy(busy), .done(done), .done_id(done_id), .err(err)
  );

  spi_cfg_writer #(.CLK_DIV(CD3), .GAP_CYCLES(GAP3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3),
    .req_addr0(req_addr3), .req_addr1(7'h00),
    .req_data0(req_data3), .req_data1(8'h00),
    .req_ready(req_ready3), .sclk(sclk3), .copi(copi3), .ncs(ncs3),
    .busy(busy3), .done(done3), .done_id(done_id3), .err(err3)
  );

  // Wire-level observer: decodes frames and plays the peripheral's register file.
  logic        ncs_prev = 1'b1, sclk_prev = 1'b0;
  int          fall_cyc = 0, low_len = 0, first_rise = 0, nbits = 0;
  logic [15:0] shreg = '0;
  logic [15:0] frames[$];
  int          done_cyc[$];
  bit          done_ids[$];
  int          err_cycs[$];
  logic [7:0]  periph [0:4];
  logic [7:0]  exp_regs [0:4];

  always @(negedge clk) begin
    if (ncs_prev === 1'b1 && ncs === 1'b0) begin
      fall_cyc <= cyc;
      nbits    <= 0;
    end
    if (ncs === 1'b0 && sclk === 1'b1 && sclk_prev === 1'b0) begin
      if (nbits == 0) first_rise <= cyc;
      shreg <= {shreg[14:0], copi};
      nbits <= nbits + 1;
    end
    if (ncs_prev === 1'b0 && ncs === 1'b1) begin
      low_len <= cyc - fall_cyc;
      if (nbits == 16) begin
        frames.push_back(shreg);
        if (shreg[15] && shreg[14:8] <= 7'd4) periph[int'(shreg[14:8])] <= shreg[7:0];
      end
    end
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_ids.push_back(done_id);
    end
    if (err === 1'b1) err_cycs.push_back(cyc);
    ncs_prev  <= ncs;
    sclk_prev <= sclk;
  end

  logic        ncs3_prev = 1'b1, sclk3_prev = 1'b0;
  int          fall3 = 0, low3 = 0, nbits3 = 0;
  logic [15:0] shreg3 = '0;
  logic [15:0] frames3[$];

  always @(negedge clk) begin
    if (ncs3_prev === 1'b1 && ncs3 === 1'b0) begin
      fall3  <= cyc;
      nbits3 <= 0;
    end
    if (ncs3 === 1'b0 && sclk3 === 1'b1 && sclk3_prev === 1'b0) begin
      shreg3 <= {shreg3[14:0], copi3};
      nbits3 <= nbits3 + 1;
    end
    if (ncs3_prev === 1'b0 && ncs3 === 1'b1) begin
      low3 <= cyc - fall3;
      if (nbits3 == 16) frames3.push_back(shreg3);
    end
    ncs3_prev  <= ncs3;
    sclk3_prev <= sclk3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hs(input bit id, output bit got, output int t);
    got = 1'b0;
    t   = 0;
    for (int k = 0; k < 400; k++) begin
      if (req_valid[id] && req_ready[id]) begin
        got = 1'b1;
        t   = cyc;
        break;
      end
      @(posedge clk); #2;
    end
  endtask

  bit last_gnt = 1'b1;

  task automatic write_one(input bit id, input logic [6:0] a, input logic [7:0] d);
    int t_hs;
    bit got;
    bit bad;
    bad = ADDR_CHECK && (a > ADDR_MAX);
    frames.delete(); done_cyc.delete(); done_ids.delete(); err_cycs.delete();
    @(posedge clk); #1;
    if (id) begin req_addr1 = a; req_data1 = d; end
    else    begin req_addr0 = a; req_data0 = d; end
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    wait_hs(id, got, t_hs);
    chk("hs_seen", 32'(got), 32'd1);
    chk("hs_onehot", 32'(req_ready), id ? 32'h2 : 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    for (int k = 0; k < 300; k++) begin
      if (done_cyc.size() > 0 || err_cycs.size() > 0) break;
      @(posedge clk); #2;
    end
    if (bad) begin
      chk("err_cycle", (err_cycs.size() > 0) ? 32'(err_cycs[0]) : 32'hFFFF_FFFF, 32'(t_hs + 1));
      chk("err_ncs_high", 32'(ncs), 32'd1);
      chk("err_not_busy", 32'(busy), 32'd0);
      chk("err_no_frame", 32'(frames.size()), 32'd0);
      chk("err_no_done", 32'(done_cyc.size()), 32'd0);
    end else begin
      chk("frame", (frames.size() > 0) ? 32'(frames[0]) : 32'hFFFF_FFFF, 32'({1'b1, a, d}));
      chk("ncs_fall", 32'(fall_cyc), 32'(t_hs + 1));
      chk("first_rise", 32'(first_rise), 32'(t_hs + 1 + CD));
      chk("ncs_low", 32'(low_len), 32'(33 * CD));
      chk("done_cycle", (done_cyc.size() > 0) ? 32'(done_cyc[0]) : 32'hFFFF_FFFF, 32'(t_hs + 1 + 33 * CD));
      chk("done_id", (done_ids.size() > 0) ? 32'(done_ids[0]) : 32'hFFFF_FFFF, 32'(id));
      chk("no_err", 32'(err_cycs.size()), 32'd0);
      if (a <= ADDR_MAX) exp_regs[int'(a)] = d;
    end
    last_gnt = id;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got, prefer, gid, upd;
    int          t_hs, t_prev, n;
    logic [1:0]  hs;
    logic [15:0] exp_frames[$];
    bit          exp_ids[$];

    for (int i = 0; i < 5; i++) begin
      periph[i]   = 8'h00;
      exp_regs[i] = 8'h00;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_copi", 32'(copi), 32'd0);
    chk("rst_ncs", 32'(ncs), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ncs3", 32'(ncs3), 32'd1);
    rst = 1'b0;

    write_one(1'b0, 7'h04, 8'hA5);
    write_one(1'b0, ADDR_EN_OUT_LO, 8'hF0);
    write_one(1'b1, ADDR_EN_PWM_HI, 8'h0F);
    chk("loop_en_out_lo", 32'(periph[0]), 32'hF0);
    chk("loop_en_pwm_hi", 32'(periph[3]), 32'h0F);

    // Continuous load on both requesters
    prefer = ~last_gnt;
    frames.delete(); done_cyc.delete(); done_ids.delete(); err_cycs.delete();
    @(posedge clk); #1;
    req_addr0 = 7'($urandom_range(0, 4));
    req_addr1 = 7'($urandom_range(0, 4));
    req_data0 = 8'($urandom);
    req_data1 = ~req_data0;
    req_valid = 2'b11;
    #1;
    n = 0; t_prev = 0; upd = 1'b0; gid = 1'b0;
    for (int k = 0; k < 1000 && n < 4; k++) begin
      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        gid = hs[1];
        chk("alt_onehot", 32'(hs), gid ? 32'h2 : 32'h1);
        chk("alt_grant", 32'(gid), 32'(prefer));
        if (n > 0) chk("alt_period", 32'(cyc - t_prev), 32'(PERIOD));
        exp_frames.push_back(gid ? {1'b1, req_addr1, req_data1} : {1'b1, req_addr0, req_data0});
        exp_ids.push_back(gid);
        if (gid) exp_regs[int'(req_addr1)] = req_data1;
        else     exp_regs[int'(req_addr0)] = req_data0;
        prefer   = ~gid;
        last_gnt = gid;
        t_prev   = cyc;
        n++;
        upd = 1'b1;
      end
      @(posedge clk); #1;
      if (upd) begin
        if (n == 4) req_valid = 2'b00;
        else if (gid) begin req_addr1 = 7'($urandom_range(0, 4)); req_data1 = 8'($urandom); end
        else           begin req_addr0 = 7'($urandom_range(0, 4)); req_data0 = 8'($urandom); end
        upd = 1'b0;
      end
      #1;
    end
    chk("alt_count", 32'(n), 32'd4);
    for (int k = 0; k < 700; k++) begin
      if (done_cyc.size() >= 4) break;
      @(posedge clk); #2;
    end
    chk("alt_frames_n", 32'(frames.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < frames.size() && i < exp_frames.size()) chk("alt_frame", 32'(frames[i]), 32'(exp_frames[i]));
      if (i < done_ids.size() && i < exp_ids.size()) chk("alt_done_id", 32'(done_ids[i]), 32'(exp_ids[i]));
    end

    for (int r = 0; r < 3; r++)
      write_one(1'($urandom_range(0, 1)), 7'($urandom_range(0, 4)), 8'($urandom));

    // Reset in the middle of a frame
    frames.delete(); done_cyc.delete(); done_ids.delete(); err_cycs.delete();
    @(posedge clk); #1;
    req_addr0 = ADDR_EN_PWM_LO;
    req_data0 = 8'($urandom) ^ exp_regs[2] ^ 8'h01;
    req_valid = 2'b01;
    #1;
    wait_hs(1'b0, got, t_hs);
    chk("abort_hs", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    for (int k = 0; k < 300; k++) begin
      if (ncs === 1'b0 && nbits == 8) break;
      @(posedge clk); #2;
    end
    chk("abort_bits", 32'(nbits), 32'd8);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("abort_ncs", 32'(ncs), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    chk("abort_no_done", 32'(done_cyc.size()), 32'd0);
    chk("abort_no_frame", 32'(frames.size()), 32'd0);
    chk("abort_reg", 32'(periph[2]), 32'(exp_regs[2]));
    last_gnt = 1'b1;

    // Address beyond the register map
    write_one(1'b1, 7'h05, 8'($urandom));

    // Minimum divider/gap instance
    @(posedge clk); #1;
    req_addr3  = ADDR_EN_OUT_HI;
    req_data3  = 8'h3C;
    req_valid3 = 2'b01;
    #1;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready3[0]) begin got = 1'b1; break; end
      @(posedge clk); #2;
    end
    chk("d3_hs", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid3 = 2'b00;
    #1;
    for (int k = 0; k < 200; k++) begin
      if (frames3.size() > 0) break;
      @(posedge clk); #2;
    end
    chk("d3_ncs_low", 32'(low3), 32'(33 * CD3));
    chk("d3_frame", (frames3.size() > 0) ? 32'(frames3[0]) : 32'hFFFF_FFFF, 32'h813C);

    for (int i = 0; i < 5; i++) chk("final_reg", 32'(periph[i]), 32'(exp_regs[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
